kernel_dispatcher: RTL and testbench
====================================

# kernel_dispatcher

Parametrised kernel dispatcher for the GPU top level. It splits a kernel's thread count into fixed-size blocks and hands them to `NUM_LOGICAL_CORES` logical cores through per-core reset/start/done handshakes. It generalises the current dispatcher with configurable counter widths and a per-core enable mask, so cores can be fenced off. An optional kernel cycle counter is included. It sits between the DCR and the core array, replacing `dispatch`.

## Interface
- `NUM_LOGICAL_CORES`, 2, number of logical cores served (≥1).
- `THREADS_PER_BLOCK`, 4, threads per block, power of two ≥1.
- `THREAD_COUNT_BITS`, 8, width of the kernel thread count.
- `BLOCK_ID_BITS`, 8, width of each core's block id; must hold ceil(2^THREAD_COUNT_BITS−1 / THREADS_PER_BLOCK).
- `TC_W` (localparam) = $clog2(THREADS_PER_BLOCK)+1.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  kernel launch, level-sensitive.
- `thread_count`  in  THREAD_COUNT_BITS  total threads; latched at launch.
- `core_enable`  in  NUM_LOGICAL_CORES  bit k=1 allows new blocks on core k.
- `core_done`  in  NUM_LOGICAL_CORES  core k finished its block.
- `core_reset`  out  NUM_LOGICAL_CORES  one-cycle reset pulse to core k.
- `core_start`  out  NUM_LOGICAL_CORES  held high while core k runs a block.
- `core_block_id`  out  NUM_LOGICAL_CORES*BLOCK_ID_BITS  flattened; slice k = block id of core k.
- `core_thread_count`  out  NUM_LOGICAL_CORES*TC_W  flattened; threads active in core k's block.
- `busy`  out  1  kernel in progress.
- `done`  out  1  kernel complete.
- `kernel_cycles`  out  32  present only with `DISPATCH_PERF_COUNTER_EN`.

## Operation
- All outputs registered. On reset every output is 0, all states are IDLE/FREE, and counters are cleared.
- Global FSM:
  - IDLE: `start`=1 latches `thread_count`, computes total_blocks = ceil(thread_count/THREADS_PER_BLOCK), clears dispatched/completed, and moves to RUN with `busy`=1.
  - RUN: if completed == total_blocks, move to DONE.
  - DONE: `done`=1 and `busy`=0. Stay until `start`=0, then go to IDLE with `done`=0.
- Per-core FSM (k), active only in RUN:
  - FREE: a block is assigned when core k is the lowest-index FREE core with `core_enable[k]`=1 and dispatched < total_blocks. On assignment:
    - `core_block_id[k]`=dispatched.
    - `core_thread_count[k]` = min(THREADS_PER_BLOCK, thread_count − dispatched·THREADS_PER_BLOCK).
    - `core_reset[k]`=1; dispatched++; go to RESET.
    - At most one assignment per cycle.
  - RESET: `core_reset[k]`=0, `core_start[k]`=1, go to RUNNING.
  - RUNNING: `core_done[k]`=1 sets `core_start[k]`=0 and completed++, then go to FREE. `core_done` is ignored in FREE/RESET.
- `core_block_id` and `core_thread_count` hold their values until the core's next assignment.
- The enable mask is sampled per assignment only. Clearing a bit never aborts a running block. If all enabled cores are cleared while blocks remain, the kernel stalls in RUN.
- `thread_count`=0 gives total_blocks=0: RUN exits immediately and no core is pulsed.
- Arithmetic: the block-size subtraction uses THREAD_COUNT_BITS+1 bits; the min() result never exceeds THREADS_PER_BLOCK.
- Async reset mid-kernel: all outputs go to 0 immediately, and the kernel is not resumed.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: `busy`=1; first assignment decided.
- Cycle 2: `core_reset[c0]`=1 with valid id and count.
- Cycle 3: `core_start[c0]`=1.
- Subsequent free cores are pulsed one cycle apart.
- After `core_done[k]` is sampled at cycle t: `core_start[k]`=0 at t+1, and core k can be pulsed again at t+2.
- `done` rises 2 cycles after the final `core_done` is sampled.
- For `thread_count`=0, `done` rises at cycle 2.

## Configuration
- `DISPATCH_PERF_COUNTER_EN` defined:
  - `kernel_cycles` clears on launch and increments every RUN cycle.
  - It saturates at 2^32−1 and holds its value through DONE and IDLE until the next launch.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- 2 cores, mask 2'b11, thread_count=8, each core asserts done 5 cycles after start:
  - Core0 gets id 0 and core1 gets id 1, both with count 4.
  - `done` goes high; with the macro enabled, `kernel_cycles` is nonzero and stable.
- thread_count=10: three blocks. Block 2 has count 2 and goes to whichever core completes first, with id 2.
- thread_count=0: `done`=1 at cycle 2 after start; `core_reset` and `core_start` never assert.
- Mask 2'b10, thread_count=12: blocks 0,1,2 all go to core1 in order; `core_reset[0]` and `core_start[0]` stay 0.
- Reset driven low while core1 is RUNNING: all outputs read 0 in the same cycle. After release, `start`=1 relaunches from block 0.
- Hold `start` high after `done`: `done` stays 1 with no relaunch. Dropping `start` gives `done`=0 on the next cycle.

Source files
------------

// File: rtl/kernel_dispatcher.sv
// Kernel dispatcher: splits a kernel into fixed-size blocks and hands them to enabled cores.
// Optional kernel cycle counter is compiled in with `define DISPATCH_PERF_COUNTER_EN.
module kernel_dispatcher #(
    parameter int NUM_LOGICAL_CORES = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int BLOCK_ID_BITS     = 8,
    localparam int TC_W             = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [THREAD_COUNT_BITS-1:0]               thread_count,
    input  logic [NUM_LOGICAL_CORES-1:0]               core_enable,
    input  logic [NUM_LOGICAL_CORES-1:0]               core_done,
    output logic [NUM_LOGICAL_CORES-1:0]               core_reset,
    output logic [NUM_LOGICAL_CORES-1:0]               core_start,
    output logic [NUM_LOGICAL_CORES*BLOCK_ID_BITS-1:0] core_block_id,
    output logic [NUM_LOGICAL_CORES*TC_W-1:0]          core_thread_count,
    output logic                                       busy,
    output logic                                       done
`ifdef DISPATCH_PERF_COUNTER_EN
    ,
    output logic [31:0]                                kernel_cycles
`endif
);

    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int CNT_W    = THREAD_COUNT_BITS + 1;
    localparam int SUM_W    = THREAD_COUNT_BITS + LOG2_TPB + 1;

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} gstate_t;
    typedef enum logic [1:0] {C_FREE, C_RESET, C_RUNNING} cstate_t;

    gstate_t                      gstate;
    gstate_t                      gstate_next;
    cstate_t                      cstate      [NUM_LOGICAL_CORES];
    cstate_t                      cstate_next [NUM_LOGICAL_CORES];
    logic [THREAD_COUNT_BITS-1:0] tc_latched;
    logic [CNT_W-1:0]             total_blocks;
    logic [CNT_W-1:0]             dispatched;
    logic [CNT_W-1:0]             completed;
    logic [CNT_W-1:0]             done_cnt;
    logic [CNT_W-1:0]             remaining;
    logic [TC_W-1:0]              block_threads;
    logic [NUM_LOGICAL_CORES-1:0] grant;
    logic                         found;
    logic                         launch;

    function automatic logic [CNT_W-1:0] ceil_blocks(input logic [THREAD_COUNT_BITS-1:0] n);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(n) + SUM_W'(THREADS_PER_BLOCK - 1);
        return CNT_W'(sum >> LOG2_TPB);
    endfunction

    function automatic logic [TC_W-1:0] clamp_threads(input logic [CNT_W-1:0] left);
        if (left >= CNT_W'(THREADS_PER_BLOCK))
            return TC_W'(THREADS_PER_BLOCK);
        return left[TC_W-1:0];
    endfunction

    assign launch        = (gstate == G_IDLE) && start;
    assign remaining     = {1'b0, tc_latched} - (dispatched << LOG2_TPB);
    assign block_threads = clamp_threads(remaining);

    // Lowest-index free enabled core wins; at most one grant per cycle.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        done_cnt = '0;
        for (int k = 0; k < NUM_LOGICAL_CORES; k++) begin
            if (!found && gstate == G_RUN && cstate[k] == C_FREE && core_enable[k]
                && dispatched < total_blocks) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
            if (cstate[k] == C_RUNNING && core_done[k])
                done_cnt = done_cnt + 1'b1;
        end
    end

    always_comb begin
        gstate_next = gstate;
        case (gstate)
            G_IDLE:  if (start) gstate_next = G_RUN;
            G_RUN:   if (completed == total_blocks) gstate_next = G_DONE;
            G_DONE:  if (!start) gstate_next = G_IDLE;
            default: gstate_next = G_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_LOGICAL_CORES; k++) begin
            cstate_next[k] = cstate[k];
            case (cstate[k])
                C_FREE:    if (grant[k]) cstate_next[k] = C_RESET;
                C_RESET:   cstate_next[k] = C_RUNNING;
                C_RUNNING: if (core_done[k]) cstate_next[k] = C_FREE;
                default:   cstate_next[k] = C_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gstate            <= G_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            tc_latched        <= '0;
            total_blocks      <= '0;
            dispatched        <= '0;
            completed         <= '0;
            core_reset        <= '0;
            core_start        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            for (int k = 0; k < NUM_LOGICAL_CORES; k++)
                cstate[k] <= C_FREE;
        end else begin
            gstate <= gstate_next;
            busy   <= (gstate_next == G_RUN);
            done   <= (gstate_next == G_DONE);
            if (launch) begin
                tc_latched   <= thread_count;
                total_blocks <= ceil_blocks(thread_count);
                dispatched   <= '0;
                completed    <= '0;
            end else begin
                if (|grant)
                    dispatched <= dispatched + 1'b1;
                completed <= completed + done_cnt;
            end
            for (int k = 0; k < NUM_LOGICAL_CORES; k++) begin
                cstate[k]     <= cstate_next[k];
                core_reset[k] <= grant[k];
                if (cstate[k] == C_RESET)
                    core_start[k] <= 1'b1;
                else if (cstate[k] == C_RUNNING && core_done[k])
                    core_start[k] <= 1'b0;
                if (grant[k]) begin
                    core_block_id[k*BLOCK_ID_BITS +: BLOCK_ID_BITS] <= BLOCK_ID_BITS'(dispatched);
                    core_thread_count[k*TC_W +: TC_W]               <= block_threads;
                end
            end
        end
    end

`ifdef DISPATCH_PERF_COUNTER_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Holds through DONE/IDLE so software can read it after completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            kernel_cycles <= '0;
        else if (launch)
            kernel_cycles <= '0;
        else if (gstate == G_RUN)
            kernel_cycles <= sat_inc32(kernel_cycles);
    end
`endif

endmodule

// File: tb/tb_kernel_dispatcher.sv
// Directed bench for kernel_dispatcher (2 cores, 4 threads per block).
// Checks kernel_cycles too when DISPATCH_PERF_COUNTER_EN is defined.
module tb_kernel_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thread_count;
    logic [1:0]  core_enable;
    logic [1:0]  core_done;
    logic [1:0]  core_reset;
    logic [1:0]  core_start;
    logic [15:0] core_block_id;
    logic [5:0]  core_thread_count;
    logic        busy;
    logic        done;
`ifdef DISPATCH_PERF_COUNTER_EN
    logic [31:0] kernel_cycles;
    logic [31:0] kc_saved;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    kernel_dispatcher dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_enable       (core_enable),
        .core_done         (core_done),
        .core_reset        (core_reset),
        .core_start        (core_start),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .busy              (busy),
        .done              (done)
`ifdef DISPATCH_PERF_COUNTER_EN
        ,
        .kernel_cycles     (kernel_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [1:0] m);
        core_done = m;
        tick();
        core_done = 2'b00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        thread_count = 8'd0;
        core_enable  = 2'b11;
        core_done    = 2'b00;
        #1;
        check("rst_core_reset", 32'(core_reset), 32'h0);
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_done",       32'(done),       32'h0);
        check("rst_ids",        32'(core_block_id), 32'h0);
        check("rst_counts",     32'(core_thread_count), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Two full blocks, one per core
        thread_count = 8'd8; core_enable = 2'b11; start = 1'b1;
        tick();
        check("t1_c1_busy",  32'(busy), 32'h1);
        check("t1_c1_reset", 32'(core_reset), 32'h0);
        tick();
        check("t1_c2_reset", 32'(core_reset), 32'h1);
        check("t1_c2_id0",   32'(core_block_id[7:0]), 32'h0);
        check("t1_c2_tc0",   32'(core_thread_count[2:0]), 32'h4);
        tick();
        check("t1_c3_reset", 32'(core_reset), 32'h2);
        check("t1_c3_start", 32'(core_start), 32'h1);
        check("t1_c3_id1",   32'(core_block_id[15:8]), 32'h1);
        check("t1_c3_tc1",   32'(core_thread_count[5:3]), 32'h4);
        tick();
        check("t1_c4_reset", 32'(core_reset), 32'h0);
        check("t1_c4_start", 32'(core_start), 32'h3);
        tick(); tick(); tick();
        pulse_done(2'b01);
        check("t1_c8_start", 32'(core_start), 32'h2);
        check("t1_c8_busy",  32'(busy), 32'h1);
        pulse_done(2'b10);
        check("t1_c9_start", 32'(core_start), 32'h0);
        check("t1_c9_done",  32'(done), 32'h0);
        tick();
        check("t1_done",     32'(done), 32'h1);
        check("t1_busy_off", 32'(busy), 32'h0);
        check("t1_hold_ids", 32'(core_block_id), 32'h0100);
`ifdef DISPATCH_PERF_COUNTER_EN
        check("t1_kc_nonzero", 32'(kernel_cycles != 0), 32'h1);
        kc_saved = kernel_cycles;
`endif
        tick();
        check("t1_done_held", 32'(done), 32'h1);
        check("t1_no_relaunch", 32'(core_reset), 32'h0);
`ifdef DISPATCH_PERF_COUNTER_EN
        check("t1_kc_stable", kernel_cycles, kc_saved);
`endif
        start = 1'b0;
        tick();
        check("t1_done_drop", 32'(done), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Three blocks; tail block of 2 goes to the first core to finish
        thread_count = 8'd10; start = 1'b1;
        tick(); tick();
        check("t2_c2_reset", 32'(core_reset), 32'h1);
        tick();
        check("t2_c3_reset", 32'(core_reset), 32'h2);
        tick();
        check("t2_c4_start", 32'(core_start), 32'h3);
        pulse_done(2'b10);
        check("t2_c5_start", 32'(core_start), 32'h1);
        tick();
        check("t2_c6_reset", 32'(core_reset), 32'h2);
        check("t2_c6_id1",   32'(core_block_id[15:8]), 32'h2);
        check("t2_c6_tc1",   32'(core_thread_count[5:3]), 32'h2);
        tick();
        check("t2_c7_start", 32'(core_start), 32'h3);
        pulse_done(2'b01);
        pulse_done(2'b10);
        check("t2_c9_start", 32'(core_start), 32'h0);
        tick();
        check("t2_done",     32'(done), 32'h1);
        check("t2_tc0",      32'(core_thread_count[2:0]), 32'h4);
        start = 1'b0;
        tick();

        // Empty kernel
        thread_count = 8'd0; start = 1'b1;
        tick();
        check("t3_c1_busy",  32'(busy), 32'h1);
        check("t3_c1_reset", 32'(core_reset), 32'h0);
        check("t3_c1_start", 32'(core_start), 32'h0);
        tick();
        check("t3_c2_done",  32'(done), 32'h1);
        check("t3_c2_busy",  32'(busy), 32'h0);
        check("t3_c2_reset", 32'(core_reset), 32'h0);
        check("t3_c2_start", 32'(core_start), 32'h0);
        start = 1'b0;
        tick();

        // Core 0 fenced off: all three blocks serialise on core 1
        thread_count = 8'd12; core_enable = 2'b10; start = 1'b1;
        tick(); tick();
        check("t4_b0_reset", 32'(core_reset), 32'h2);
        check("t4_b0_id",    32'(core_block_id[15:8]), 32'h0);
        tick();
        check("t4_b0_start", 32'(core_start), 32'h2);
        pulse_done(2'b10);
        check("t4_b0_end",   32'(core_start), 32'h0);
        tick();
        check("t4_b1_reset", 32'(core_reset), 32'h2);
        check("t4_b1_id",    32'(core_block_id[15:8]), 32'h1);
        tick();
        check("t4_b1_start", 32'(core_start), 32'h2);
        pulse_done(2'b10);
        tick();
        check("t4_b2_reset", 32'(core_reset), 32'h2);
        check("t4_b2_id",    32'(core_block_id[15:8]), 32'h2);
        check("t4_b2_tc",    32'(core_thread_count[5:3]), 32'h4);
        tick();
        check("t4_b2_start", 32'(core_start), 32'h2);
        pulse_done(2'b10);
        tick();
        check("t4_done",     32'(done), 32'h1);
        start = 1'b0;
        tick();

        // Asynchronous reset mid-kernel, then relaunch from block 0
        thread_count = 8'd8; core_enable = 2'b11; start = 1'b1;
        tick(); tick(); tick(); tick();
        check("t5_running",  32'(core_start), 32'h3);
        reset = 1'b0;
        #1;
        check("t5_rst_start", 32'(core_start), 32'h0);
        check("t5_rst_busy",  32'(busy), 32'h0);
        check("t5_rst_ids",   32'(core_block_id), 32'h0);
        check("t5_rst_tcs",   32'(core_thread_count), 32'h0);
`ifdef DISPATCH_PERF_COUNTER_EN
        check("t5_rst_kc",    kernel_cycles, 32'h0);
`endif
        reset = 1'b1;
        tick();
        check("t5_relaunch_busy", 32'(busy), 32'h1);
        tick();
        check("t5_relaunch_reset", 32'(core_reset), 32'h1);
        check("t5_relaunch_id0",   32'(core_block_id[7:0]), 32'h0);
        tick();
        check("t5_relaunch_id1",   32'(core_block_id[15:8]), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
